param_loader: RTL
=================

Name: param_loader

Overview:
- Generalised successor to the per-layer bias/weight loaders.
- Streams a contiguous run of bytes from the shared single-port parameter BRAM into a packed, register-backed parameter vector for one layer.
- Run length, element width, base address and BRAM read latency are all parameters; the base address can also be overridden at run time.
- Adds reset, a restart capability and a busy indication; it sits between the BRAM arbiter and a layer's MAC array.

Parameters:
- NUM_ELEMS, 8: number of parameter elements to load.
- ELEM_W, 8: element width in bits; must be a multiple of BRAM_W.
- BRAM_W, 8: BRAM data width.
- ADDR_WIDTH, 15: BRAM address width.
- BASE_ADDR, 16432: default start address.
- RD_LAT, 2: BRAM read latency in cycles, from address to dout; legal range 1..4.
- TOTAL_WORDS, NUM_ELEMS*ELEM_W/BRAM_W: derived; BRAM reads per load.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load request; sampled only in IDLE or DONE.
- use_ext_base  in  1  when 1 at the accepted start, ext_base replaces BASE_ADDR.
- ext_base  in  ADDR_WIDTH  run-time base address.
- bram_en  out  1  BRAM enable.
- bram_ren  out  1  BRAM read enable.
- bram_addr  out  ADDR_WIDTH  BRAM address.
- bram_dout  in  BRAM_W  BRAM read data, valid RD_LAT cycles after address.
- data_out  out  NUM_ELEMS*ELEM_W  packed parameters; element i at [i*ELEM_W +: ELEM_W].
- busy  out  1  high in ISSUE or DRAIN.
- done  out  1  high in DONE, held until next accepted start.

Behaviour:
- Reset, asynchronous while rst_n=0: state=IDLE, all counters 0, bram_en=bram_ren=0, bram_addr=BASE_ADDR, data_out=0, busy=0, done=0.
- Reset mid-load aborts immediately. data_out keeps no partial contents; it is cleared to 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE + start=1:
  - Latch base as ext_base if use_ext_base, else BASE_ADDR.
  - bram_addr=base, issue_cnt=0, wr_ptr=0, done=0.
  - bram_en=bram_ren=1.
  - Go to ISSUE.
- Restart from DONE is legal. data_out keeps its old contents until each word is overwritten.
- start in ISSUE/DRAIN is ignored; no queueing.
- ISSUE:
  - One address per cycle; each cycle the current bram_addr counts as one issued read.
  - issue_cnt increments and bram_addr increments, until issue_cnt reaches TOTAL_WORDS-1.
  - On that cycle, go to DRAIN and deassert bram_ren the next cycle.
  - Exactly TOTAL_WORDS addresses are presented: base..base+TOTAL_WORDS-1.
- Return tracking:
  - An RD_LAT-deep valid shift register is fed with 1 for each issued address.
  - When its output is 1, bram_dout is written to data_out word slice [wr_ptr*BRAM_W +: BRAM_W], and wr_ptr increments.
  - Byte order within an element is little-endian: the lowest address holds the least significant byte.
- DRAIN: bram_en stays high until wr_ptr==TOTAL_WORDS, then DONE with bram_en=0.
- Latency: start accepted at edge 0 → done high after edge TOTAL_WORDS+RD_LAT+1. The bench checks this exact count.
- bram_addr wrap-around: addresses wrap modulo 2^ADDR_WIDTH, with no error flag.
- busy and done are never both high.
- Elaboration errors:
  - ELEM_W % BRAM_W != 0.
  - RD_LAT outside 1..4.
  - NUM_ELEMS == 0.

Decomposition:
- Package param_loader_pkg:
  - state enum {IDLE, ISSUE, DRAIN, DONE}.
  - BIAS base-address constants per layer (e.g. L1_BIAS_BASE=16432).
  - RD_LAT_MAX=4.
- Sub-module bram_rd_pipe(DEPTH): valid shift register with asynchronous active-low reset and a synchronous flush input. The top level asserts flush on start.

Test Plan:
- Defaults, BRAM[16432..16439]=0x01..0x08, start pulse → done exactly 11 cycles after start; data_out=0x0807060504030201; bram_en=0 in DONE.
- ELEM_W=16, NUM_ELEMS=2, BRAM[16432..16435]=AA,BB,CC,DD → element0=0xBBAA, element1=0xDDCC.
- use_ext_base=1, ext_base=0x7FFE, NUM_ELEMS=4 → addresses 7FFE,7FFF,0000,0001 issued; data packed in that order.
- rst_n pulled low at the 4th ISSUE cycle → outputs take reset values immediately. A new start then loads the full vector correctly.
- start asserted every cycle during the load → single load only, done timing unchanged. A start in DONE clears done the next cycle and reloads new BRAM contents.
- RD_LAT=1 and RD_LAT=4 builds → done at TOTAL_WORDS+RD_LAT+1 cycles; data identical to the RD_LAT=2 build.

Source files
------------

// File: rtl/param_loader_pkg.sv
// Shared types and constants for the layer parameter loaders.
// The state encoding and per-layer BRAM base addresses live here so every loader instance agrees on them.
package param_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Start of the layer-1 bias block in the shared parameter BRAM.
  localparam int unsigned L1_BIAS_BASE = 16432;

  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/param_loader_rd_pipe.sv
// Read-return tracker: a DEPTH-stage valid shift register that marks the cycle on which
// each issued BRAM read presents its data. The flush input discards in-flight reads when a new load starts.
module bram_rd_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic valid_in,
  output logic valid_out
);

  logic [DEPTH-1:0] sr;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (flush) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(valid_in);
    end
  end

  assign valid_out = sr[DEPTH-1];

endmodule

// File: rtl/param_loader.sv
// Streams TOTAL_WORDS consecutive BRAM words into a packed, register-backed parameter vector.
// Word k of the run lands at data_out[k*BRAM_W +: BRAM_W], so each element is little-endian in address order.
module param_loader
  import param_loader_pkg::*;
#(
  parameter int          NUM_ELEMS   = 8,
  parameter int          ELEM_W      = 8,
  parameter int          BRAM_W      = 8,
  parameter int          ADDR_WIDTH  = 15,
  parameter int unsigned BASE_ADDR   = L1_BIAS_BASE,
  parameter int          RD_LAT      = 2,
  parameter int          TOTAL_WORDS = NUM_ELEMS * ELEM_W / BRAM_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        use_ext_base,
  input  logic [ADDR_WIDTH-1:0]       ext_base,
  output logic                        bram_en,
  output logic                        bram_ren,
  output logic [ADDR_WIDTH-1:0]       bram_addr,
  input  logic [BRAM_W-1:0]           bram_dout,
  output logic [NUM_ELEMS*ELEM_W-1:0] data_out,
  output logic                        busy,
  output logic                        done
);

  localparam int CNT_W = $clog2(TOTAL_WORDS + 1);

  if (NUM_ELEMS == 0) begin : g_err_elems
    $error("param_loader: NUM_ELEMS must be non-zero");
  end
  if (ELEM_W % BRAM_W != 0) begin : g_err_width
    $error("param_loader: ELEM_W must be a multiple of BRAM_W");
  end
  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_err_lat
    $error("param_loader: RD_LAT must be in 1..RD_LAT_MAX");
  end

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   issue_cnt;
  logic [CNT_W-1:0]   wr_ptr;
  logic               accept;
  logic               last_issue;
  logic               rd_valid;

  assign accept     = start && (state == IDLE || state == DONE);
  assign last_issue = (issue_cnt == CNT_W'(TOTAL_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    bram_en   = 1'b0;
    bram_ren  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        bram_en  = 1'b1;
        bram_ren = 1'b1;
        busy     = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        bram_en = 1'b1;
        busy    = 1'b1;
        if (wr_ptr == CNT_W'(TOTAL_WORDS)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every ISSUE cycle presents one read; the pipe raises rd_valid when its data is on bram_dout.
  bram_rd_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (accept),
    .valid_in  (state == ISSUE),
    .valid_out (rd_valid)
  );

  // NOTE: data_out is a flop vector, not a RAM, so it is reset; an aborted load must leave no partial contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_addr <= ADDR_WIDTH'(BASE_ADDR);
      issue_cnt <= '0;
      wr_ptr    <= '0;
      data_out  <= '0;
    end else begin
      if (rd_valid) begin
        data_out[wr_ptr*BRAM_W +: BRAM_W] <= bram_dout;
        wr_ptr                            <= wr_ptr + CNT_W'(1);
      end
      if (accept) begin
        bram_addr <= use_ext_base ? ext_base : ADDR_WIDTH'(BASE_ADDR);
        issue_cnt <= '0;
        wr_ptr    <= '0;
      end else if (state == ISSUE && !last_issue) begin
        // Address wraps modulo 2^ADDR_WIDTH by plain overflow.
        bram_addr <= bram_addr + ADDR_WIDTH'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

endmodule
